// File: rtl/myproject_mul_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one unsigned multiplier among NUM_REQ requesters.
// The result pipeline freezes as a whole when the output is held off by rsp_ready.
module myproject_mul_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int din0_WIDTH = 31,
   parameter int din1_WIDTH = 11,
   parameter int dout_WIDTH = 41,
   parameter int NUM_STAGE  = 2,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst_n,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*din0_WIDTH-1:0]    req_din0,
   input  logic [NUM_REQ*din1_WIDTH-1:0]    req_din1,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [ID_W-1:0]                  rsp_id,
   output logic [dout_WIDTH-1:0]            rsp_dout,
   output logic                             busy
);

   localparam int OPW = din0_WIDTH + din1_WIDTH;
   localparam int MW  = (OPW > dout_WIDTH) ? OPW : dout_WIDTH;
   localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]       r_rr_ptr;
   logic [NUM_STAGE-1:0]  r_vld;
   logic [ID_W-1:0]       r_id   [NUM_STAGE];
   logic [dout_WIDTH-1:0] r_prod [NUM_STAGE];

   logic                  w_stall;
   logic                  w_adv;
   logic                  w_any;
   logic                  w_xfer;
   logic [ID_W-1:0]       w_gnt_idx;
   logic [ID_W:0]         w_sum;
   logic [NUM_REQ-1:0]    w_rot;
   logic [din0_WIDTH-1:0] w_a;
   logic [din1_WIDTH-1:0] w_b;
   logic [MW-1:0]         w_a_ext;
   logic [MW-1:0]         w_b_ext;
   logic [dout_WIDTH-1:0] w_prod;

   assign w_stall = r_vld[NUM_STAGE-1] & ~rsp_ready;
   assign w_adv   = ~w_stall;

   // Bit k of w_rot is requester (rr_ptr + k) mod NUM_REQ.
   assign w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);

   // Scan from the far end so the lowest rotated offset wins.
   always_comb begin
      w_any     = 1'b0;
      w_gnt_idx = '0;
      w_sum     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= NUM_REQ_X) begin
               w_sum = w_sum - NUM_REQ_X;
            end
            w_any     = 1'b1;
            w_gnt_idx = w_sum[ID_W-1:0];
         end
      end
   end

   assign w_xfer = w_any & w_adv & ap_rst_n;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
         assign req_ready[gi] = w_xfer & (w_gnt_idx == ID_W'(gi));
      end
   endgenerate

   always_comb begin
      w_a = '0;
      w_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt_idx == ID_W'(i)) begin
            w_a = req_din0[i*din0_WIDTH +: din0_WIDTH];
            w_b = req_din1[i*din1_WIDTH +: din1_WIDTH];
         end
      end
   end

   assign w_a_ext = MW'(w_a);
   assign w_b_ext = MW'(w_b);
   // Product enters stage 0; the later stages give synthesis room to retime the multiplier.
   assign w_prod  = dout_WIDTH'(w_a_ext * w_b_ext);

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rr_ptr <= '0;
         r_vld    <= '0;
         for (int s = 0; s < NUM_STAGE; s++) begin
            r_id[s]   <= '0;
            r_prod[s] <= '0;
         end
      end else begin
         if (w_xfer) begin
            r_rr_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
         end
         if (w_adv) begin
            r_vld[0]  <= w_xfer;
            r_id[0]   <= w_gnt_idx;
            r_prod[0] <= w_prod;
            for (int s = 1; s < NUM_STAGE; s++) begin
               r_vld[s]  <= r_vld[s-1];
               r_id[s]   <= r_id[s-1];
               r_prod[s] <= r_prod[s-1];
            end
         end
      end
   end

   assign rsp_valid = r_vld[NUM_STAGE-1];
   assign rsp_id    = r_id[NUM_STAGE-1];
   assign rsp_dout  = r_prod[NUM_STAGE-1];
   assign busy      = |r_vld;

endmodule

// File: tb/tb_myproject_mul_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for myproject_mul_arbiter: a negedge monitor models the round-robin
// grant, queues expected products on each transfer and matches them against results.
module tb_myproject_mul_arbiter;

   localparam int NR = 4;
   localparam int W0 = 31;
   localparam int W1 = 11;
   localparam int DW = 41;
   localparam int NS = 2;
   localparam logic [63:0] MASK = (64'd1 << DW) - 64'd1;

   logic                ap_clk = 1'b0;
   logic                ap_rst_n;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_ready;
   logic [NR*W0-1:0]    req_din0;
   logic [NR*W1-1:0]    req_din1;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [1:0]          rsp_id;
   logic [DW-1:0]       rsp_dout;
   logic                busy;

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;

   int          q_id[$];
   logic [63:0] q_dout[$];
   int          q_cyc[$];
   int          g_log[$];
   int          g_cyc[$];

   int          m_ptr = 0;
   logic        lat_chk = 1'b0;
   logic        rand_ops = 1'b0;
   int          last_id;
   logic [63:0] last_dout;
   int          last_lat;

   myproject_mul_arbiter #(
      .NUM_REQ(NR), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(DW), .NUM_STAGE(NS)
   ) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_din0(req_din0), .req_din1(req_din1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_dout(rsp_dout), .busy(busy)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
      if (rand_ops) begin
         for (int i = 0; i < NR; i++) begin
            req_din0[i*W0 +: W0] = W0'($urandom);
            req_din1[i*W1 +: W1] = W1'($urandom);
         end
      end
   endtask

   task automatic go_grants(input logic [NR-1:0] vec, input int n);
      int target;
      int k;
      req_valid = vec;
      target = g_log.size() + n;
      k = 0;
      while (g_log.size() < target && k < 200) begin
         tick();
         k++;
      end
      check_eq("grant_timeout", 64'(g_log.size() >= target), 64'd1);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (q_id.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      check_eq("drain", 64'(q_id.size()), 64'd0);
      tick();
   endtask

   // Monitor: grant model, stall stability and result scoreboard.
   logic        p_stall = 1'b0;
   logic        p_valid;
   logic [1:0]  p_id;
   logic [DW-1:0] p_dout;
   logic        m_stall;
   logic [NR-1:0] m_rdy;
   int          m_g;
   int          m_i;
   int          e_id;
   logic [63:0] e_dout;
   int          e_cyc;
   logic [63:0] a64;
   logic [63:0] b64;

   initial begin
      forever begin
         @(negedge ap_clk);
         if (ap_rst_n) begin
            check_eq("busy", 64'(busy), 64'(q_id.size() != 0));
            m_stall = rsp_valid & ~rsp_ready;
            m_rdy = '0;
            m_g = -1;
            if (!m_stall) begin
               for (int k = 0; k < NR; k++) begin
                  m_i = (m_ptr + k) % NR;
                  if (m_g < 0 && req_valid[m_i]) m_g = m_i;
               end
            end
            if (m_g >= 0) m_rdy[m_g] = 1'b1;
            check_eq("req_ready", 64'(req_ready), 64'(m_rdy));
            if (p_stall) begin
               check_eq("stall_valid", 64'(rsp_valid), 64'(p_valid));
               check_eq("stall_id", 64'(rsp_id), 64'(p_id));
               check_eq("stall_dout", 64'(rsp_dout), 64'(p_dout));
            end
            if (rsp_valid && rsp_ready) begin
               if (q_id.size() == 0) begin
                  check_eq("rsp_unexpected", 64'd1, 64'd0);
               end else begin
                  e_id = q_id.pop_front();
                  e_dout = q_dout.pop_front();
                  e_cyc = q_cyc.pop_front();
                  last_id = int'(rsp_id);
                  last_dout = 64'(rsp_dout);
                  last_lat = cyc_cnt - e_cyc;
                  $display("rsp id=%0d dout=0x%0h lat=%0d", rsp_id, rsp_dout, last_lat);
                  check_eq("rsp_id", 64'(rsp_id), 64'(e_id));
                  check_eq("rsp_dout", 64'(rsp_dout), e_dout);
                  if (lat_chk) check_eq("latency", 64'(last_lat), 64'(NS));
               end
            end
            if (m_g >= 0) begin
               a64 = 64'(req_din0[m_g*W0 +: W0]);
               b64 = 64'(req_din1[m_g*W1 +: W1]);
               q_id.push_back(m_g);
               q_dout.push_back((a64 * b64) & MASK);
               q_cyc.push_back(cyc_cnt);
               g_log.push_back(m_g);
               g_cyc.push_back(cyc_cnt);
               m_ptr = (m_g + 1) % NR;
            end
            p_stall = m_stall;
            p_valid = rsp_valid;
            p_id    = rsp_id;
            p_dout  = rsp_dout;
         end
      end
   end

   int s;
   int exp_sp[4];

   initial begin
      ap_rst_n  = 1'b1;
      req_valid = '0;
      req_din0  = '0;
      req_din1  = '0;
      rsp_ready = 1'b1;
      #2 ap_rst_n = 1'b0;
      req_valid = '1;
      #2;
      check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_rsp_id", 64'(rsp_id), 64'd0);
      check_eq("rst_rsp_dout", 64'(rsp_dout), 64'd0);
      repeat (2) @(posedge ap_clk);
      #2 ap_rst_n = 1'b1;
      req_valid = '0;
      tick();

      // All requesters continuously valid: 0,1,2,3,0,... one per cycle.
      lat_chk  = 1'b1;
      rand_ops = 1'b1;
      s = g_log.size();
      go_grants(4'b1111, 8);
      req_valid = '0;
      for (int i = 0; i < 8; i++) check_eq("all_order", 64'(g_log[s+i]), 64'(i % NR));
      check_eq("all_rate", 64'(g_cyc[s+7] - g_cyc[s]), 64'd7);
      drain();

      // Single request from requester 2 with maximal operands.
      rand_ops = 1'b0;
      req_din0[2*W0 +: W0] = 31'h7FFF_FFFF;
      req_din1[2*W1 +: W1] = 11'h7FF;
      go_grants(4'b0100, 1);
      req_valid = '0;
      drain();
      check_eq("single_id", 64'(last_id), 64'd2);
      check_eq("single_dout", last_dout, 64'h1FF_7FFF_F801);
      check_eq("single_lat", 64'(last_lat), 64'(NS));

      // Zero operand from requester 1; leaves the pointer at 2.
      req_din0[1*W0 +: W0] = '0;
      req_din1[1*W1 +: W1] = 11'h5A5;
      go_grants(4'b0010, 1);
      req_valid = '0;
      drain();
      check_eq("zero_id", 64'(last_id), 64'd1);
      check_eq("zero_dout", last_dout, 64'd0);

      // Sparse requesters 1 and 3 with pointer at 2.
      rand_ops = 1'b1;
      exp_sp = '{3, 1, 3, 1};
      s = g_log.size();
      go_grants(4'b1010, 4);
      req_valid = '0;
      for (int i = 0; i < 4; i++) check_eq("sparse_order", 64'(g_log[s+i]), 64'(exp_sp[i]));
      drain();

      // Backpressure with the pipe full.
      lat_chk = 1'b0;
      go_grants(4'b1111, NS + 2);
      rsp_ready = 1'b0;
      repeat (5) tick();
      check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_req_ready", 64'(req_ready), 64'd0);
      rsp_ready = 1'b1;
      go_grants(4'b1111, 4);
      req_valid = '0;
      drain();

      // Random traffic and random backpressure.
      for (int i = 0; i < 60; i++) begin
         req_valid = NR'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      drain();

      // Reset with two results in flight.
      go_grants(4'b0011, 2);
      req_valid = '0;
      check_eq("mid_busy_before", 64'(busy), 64'd1);
      #1 ap_rst_n = 1'b0;
      q_id.delete();
      q_dout.delete();
      q_cyc.delete();
      m_ptr = 0;
      p_stall = 1'b0;
      #1;
      check_eq("mid_rsp_valid", 64'(rsp_valid), 64'd0);
      check_eq("mid_busy", 64'(busy), 64'd0);
      req_valid = '1;
      #1;
      check_eq("mid_req_ready", 64'(req_ready), 64'd0);
      repeat (2) @(posedge ap_clk);
      #2 ap_rst_n = 1'b1;
      req_valid = 4'b0100;
      s = g_log.size();
      tick();
      req_valid = '0;
      check_eq("first_grant", 64'(g_log.size() - s), 64'd1);
      drain();
      check_eq("post_rst_id", 64'(last_id), 64'd2);
      repeat (4) tick();
      check_eq("post_rst_idle", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
